// File: rtl/ld_rs_queue.sv
// rtl/ld_rs_queue.sv - load reservation station: CDB wakeup, age-ordered AGU issue, STQ check, mem/fwd issue
module ld_rs_queue #(
    parameter int ENTRIES   = 4,
    parameter int STQ_DEPTH = 8,
    parameter int TAG_WIDTH = 6,
    parameter int XLEN      = 32,
    parameter int CDB_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [TAG_WIDTH-1:0]           rob_head,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [TAG_WIDTH-1:0]           disp_tag,
    input  logic                           disp_base_rdy,
    input  logic [TAG_WIDTH-1:0]           disp_base_tag,
    input  logic [XLEN-1:0]                disp_base,
    input  logic [XLEN-1:0]                disp_imm,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]      cdb_data,
    output logic                           agu_valid,
    input  logic                           agu_ready,
    output logic [TAG_WIDTH-1:0]           agu_tag,
    output logic [XLEN-1:0]                agu_base,
    output logic [XLEN-1:0]                agu_imm,
    input  logic                           agu_resp_valid,
    input  logic [TAG_WIDTH-1:0]           agu_resp_tag,
    input  logic [XLEN-1:0]                agu_resp_addr,
    input  logic [STQ_DEPTH-1:0]           stq_valid,
    input  logic [STQ_DEPTH-1:0]           stq_addr_valid,
    input  logic [STQ_DEPTH-1:0]           stq_data_valid,
    input  logic [STQ_DEPTH*TAG_WIDTH-1:0] stq_tag,
    input  logic [STQ_DEPTH*XLEN-1:0]      stq_addr,
    input  logic [STQ_DEPTH*XLEN-1:0]      stq_data,
    output logic                           mem_valid,
    input  logic                           mem_ready,
    output logic [TAG_WIDTH-1:0]           mem_tag,
    output logic [XLEN-1:0]                mem_addr,
    output logic                           fwd_valid,
    input  logic                           fwd_ready,
    output logic [TAG_WIDTH-1:0]           fwd_tag,
    output logic [XLEN-1:0]                fwd_data
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [2:0] {FREE, WAIT_REG, AGU_RDY, AGU_PEND, ADDR_RDY} ent_state_e;

    ent_state_e           st_q   [ENTRIES];
    ent_state_e           st_d   [ENTRIES];
    logic [TAG_WIDTH-1:0] tag_q  [ENTRIES];
    logic [TAG_WIDTH-1:0] tag_d  [ENTRIES];
    logic [TAG_WIDTH-1:0] btag_q [ENTRIES];
    logic [TAG_WIDTH-1:0] btag_d [ENTRIES];
    logic [XLEN-1:0]      base_q [ENTRIES];
    logic [XLEN-1:0]      base_d [ENTRIES];
    logic [XLEN-1:0]      imm_q  [ENTRIES];
    logic [XLEN-1:0]      imm_d  [ENTRIES];
    logic [XLEN-1:0]      addr_q [ENTRIES];
    logic [XLEN-1:0]      addr_d [ENTRIES];

    logic [TAG_WIDTH-1:0] ent_age     [ENTRIES];
    logic [TAG_WIDTH-1:0] stq_age     [STQ_DEPTH];
    logic                 ent_hit     [ENTRIES];
    logic [XLEN-1:0]      ent_cdb_val [ENTRIES];
    logic                 mem_elig    [ENTRIES];
    logic                 fwd_elig    [ENTRIES];
    logic [XLEN-1:0]      fwd_val     [ENTRIES];
    logic                 disp_hit;
    logic [XLEN-1:0]      disp_cdb_val;

    logic                 have_free, agu_found, mem_found, fwd_found;
    logic [IW-1:0]        free_idx, agu_idx, mem_idx, fwd_idx;
    logic [TAG_WIDTH-1:0] agu_best, mem_best, fwd_best;
    logic                 blk, hit, hit_dv;
    logic [TAG_WIDTH-1:0] hit_age;
    logic [XLEN-1:0]      hit_data;
    logic                 disp_fire;

    // Ports are scanned high-to-low so the lowest matching port has the final say.
    always_comb begin
        disp_hit     = 1'b0;
        disp_cdb_val = '0;
        for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == disp_base_tag) begin
                disp_hit     = 1'b1;
                disp_cdb_val = cdb_data[p*XLEN +: XLEN];
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            ent_hit[i]     = 1'b0;
            ent_cdb_val[i] = '0;
            ent_age[i]     = tag_q[i] - rob_head;
            for (int p = CDB_PORTS-1; p >= 0; p--) begin
                if (cdb_valid[p] && cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == btag_q[i]) begin
                    ent_hit[i]     = 1'b1;
                    ent_cdb_val[i] = cdb_data[p*XLEN +: XLEN];
                end
            end
        end
        for (int s = 0; s < STQ_DEPTH; s++) begin
            stq_age[s] = stq_tag[s*TAG_WIDTH +: TAG_WIDTH] - rob_head;
        end
    end

    always_comb begin
        blk      = 1'b0;
        hit      = 1'b0;
        hit_dv   = 1'b0;
        hit_age  = '0;
        hit_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            blk      = 1'b0;
            hit      = 1'b0;
            hit_dv   = 1'b0;
            hit_age  = '0;
            hit_data = '0;
            for (int s = 0; s < STQ_DEPTH; s++) begin
                if (stq_valid[s] && stq_age[s] < ent_age[i]) begin
                    if (!stq_addr_valid[s]) begin
                        blk = 1'b1;
                    end else if (stq_addr[s*XLEN +: XLEN] == addr_q[i] && (!hit || stq_age[s] > hit_age)) begin
                        hit      = 1'b1;
                        hit_age  = stq_age[s];
                        hit_dv   = stq_data_valid[s];
                        hit_data = stq_data[s*XLEN +: XLEN];
                    end
                end
            end
            mem_elig[i] = (st_q[i] == ADDR_RDY) && !blk && !hit;
            fwd_elig[i] = (st_q[i] == ADDR_RDY) && !blk && hit && hit_dv;
            fwd_val[i]  = hit_data;
        end
    end

    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        agu_found = 1'b0;
        agu_idx   = '0;
        agu_best  = '0;
        mem_found = 1'b0;
        mem_idx   = '0;
        mem_best  = '0;
        fwd_found = 1'b0;
        fwd_idx   = '0;
        fwd_best  = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (st_q[i] == FREE) begin
                have_free = 1'b1;
                free_idx  = IW'(i);
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (st_q[i] == AGU_RDY && (!agu_found || ent_age[i] < agu_best)) begin
                agu_found = 1'b1;
                agu_idx   = IW'(i);
                agu_best  = ent_age[i];
            end
            if (mem_elig[i] && (!mem_found || ent_age[i] < mem_best)) begin
                mem_found = 1'b1;
                mem_idx   = IW'(i);
                mem_best  = ent_age[i];
            end
            if (fwd_elig[i] && (!fwd_found || ent_age[i] < fwd_best)) begin
                fwd_found = 1'b1;
                fwd_idx   = IW'(i);
                fwd_best  = ent_age[i];
            end
        end
    end

    assign disp_ready = have_free;
    assign disp_fire  = disp_valid && have_free && !flush;
    assign agu_valid  = agu_found;
    assign agu_tag    = tag_q[agu_idx];
    assign agu_base   = base_q[agu_idx];
    assign agu_imm    = imm_q[agu_idx];
    assign mem_valid  = mem_found;
    assign mem_tag    = tag_q[mem_idx];
    assign mem_addr   = addr_q[mem_idx];
    assign fwd_valid  = fwd_found;
    assign fwd_tag    = tag_q[fwd_idx];
    assign fwd_data   = fwd_val[fwd_idx];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            st_d[i]   = st_q[i];
            tag_d[i]  = tag_q[i];
            btag_d[i] = btag_q[i];
            base_d[i] = base_q[i];
            imm_d[i]  = imm_q[i];
            addr_d[i] = addr_q[i];
            case (st_q[i])
                WAIT_REG: if (ent_hit[i]) begin
                    st_d[i]   = AGU_RDY;
                    base_d[i] = ent_cdb_val[i];
                end
                AGU_RDY: if (agu_ready && agu_found && agu_idx == IW'(i)) st_d[i] = AGU_PEND;
                AGU_PEND: if (agu_resp_valid && agu_resp_tag == tag_q[i]) begin
                    st_d[i]   = ADDR_RDY;
                    addr_d[i] = agu_resp_addr;
                end
                ADDR_RDY: if ((mem_ready && mem_found && mem_idx == IW'(i)) ||
                              (fwd_ready && fwd_found && fwd_idx == IW'(i))) st_d[i] = FREE;
                default: ;
            endcase
            if (disp_fire && free_idx == IW'(i)) begin
                st_d[i]   = (disp_base_rdy || disp_hit) ? AGU_RDY : WAIT_REG;
                tag_d[i]  = disp_tag;
                btag_d[i] = disp_base_tag;
                base_d[i] = disp_base_rdy ? disp_base : disp_cdb_val;
                imm_d[i]  = disp_imm;
            end
            if (flush) st_d[i] = FREE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                st_q[i]   <= FREE;
                tag_q[i]  <= '0;
                btag_q[i] <= '0;
                base_q[i] <= '0;
                imm_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                st_q[i]   <= st_d[i];
                tag_q[i]  <= tag_d[i];
                btag_q[i] <= btag_d[i];
                base_q[i] <= base_d[i];
                imm_q[i]  <= imm_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end
endmodule

// File: tb/tb_ld_rs_queue.sv
// tb/tb_ld_rs_queue.sv - directed vector bench for ld_rs_queue
module tb_ld_rs_queue;
    localparam int EN = 4, SD = 8, TW = 6, XL = 32, CP = 2;

    logic                clk = 1'b0;
    logic                rst_n, flush, disp_valid, disp_ready, disp_base_rdy;
    logic [TW-1:0]       rob_head, disp_tag, disp_base_tag;
    logic [XL-1:0]       disp_base, disp_imm;
    logic [CP-1:0]       cdb_valid;
    logic [CP*TW-1:0]    cdb_tag;
    logic [CP*XL-1:0]    cdb_data;
    logic                agu_valid, agu_ready, agu_resp_valid;
    logic [TW-1:0]       agu_tag, agu_resp_tag;
    logic [XL-1:0]       agu_base, agu_imm, agu_resp_addr;
    logic [SD-1:0]       stq_valid, stq_addr_valid, stq_data_valid;
    logic [SD*TW-1:0]    stq_tag;
    logic [SD*XL-1:0]    stq_addr, stq_data;
    logic                mem_valid, mem_ready, fwd_valid, fwd_ready;
    logic [TW-1:0]       mem_tag, fwd_tag;
    logic [XL-1:0]       mem_addr, fwd_data;

    always #5 clk = ~clk;

    ld_rs_queue #(.ENTRIES(EN), .STQ_DEPTH(SD), .TAG_WIDTH(TW), .XLEN(XL), .CDB_PORTS(CP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .disp_base_rdy(disp_base_rdy), .disp_base_tag(disp_base_tag),
        .disp_base(disp_base), .disp_imm(disp_imm),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .agu_valid(agu_valid), .agu_ready(agu_ready), .agu_tag(agu_tag),
        .agu_base(agu_base), .agu_imm(agu_imm),
        .agu_resp_valid(agu_resp_valid), .agu_resp_tag(agu_resp_tag), .agu_resp_addr(agu_resp_addr),
        .stq_valid(stq_valid), .stq_addr_valid(stq_addr_valid), .stq_data_valid(stq_data_valid),
        .stq_tag(stq_tag), .stq_addr(stq_addr), .stq_data(stq_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_tag(mem_tag), .mem_addr(mem_addr),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_tag(fwd_tag), .fwd_data(fwd_data)
    );

    typedef struct packed {
        logic          flush;
        logic [TW-1:0] head;
        logic          dv, drdy;
        logic [TW-1:0] dtag, dbtag;
        logic [XL-1:0] dbase, dimm;
        logic [1:0]    cv;
        logic [TW-1:0] ct0, ct1;
        logic [XL-1:0] cd0, cd1;
        logic          ar, rv;
        logic [TW-1:0] rtag;
        logic [XL-1:0] raddr;
        logic [1:0]    sv, sav, sdv;
        logic [TW-1:0] st0, st1;
        logic [XL-1:0] sa0, sa1, sd0, sd1;
        logic          mr, fr;
        logic          e_rdy, e_agu, e_mem, e_fwd;
        logic [TW-1:0] e_atag, e_mtag, e_ftag;
        logic [XL-1:0] e_abase, e_aimm, e_maddr, e_fdata;
    } vec_t;

    vec_t tbl[$];
    vec_t t;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush          = v.flush;
        rob_head       = v.head;
        disp_valid     = v.dv;
        disp_tag       = v.dtag;
        disp_base_rdy  = v.drdy;
        disp_base_tag  = v.dbtag;
        disp_base      = v.dbase;
        disp_imm       = v.dimm;
        cdb_valid      = v.cv;
        cdb_tag        = {v.ct1, v.ct0};
        cdb_data       = {v.cd1, v.cd0};
        agu_ready      = v.ar;
        agu_resp_valid = v.rv;
        agu_resp_tag   = v.rtag;
        agu_resp_addr  = v.raddr;
        stq_valid      = {{(SD-2){1'b0}}, v.sv};
        stq_addr_valid = {{(SD-2){1'b0}}, v.sav};
        stq_data_valid = {{(SD-2){1'b0}}, v.sdv};
        stq_tag        = {{((SD-2)*TW){1'b0}}, v.st1, v.st0};
        stq_addr       = {{((SD-2)*XL){1'b0}}, v.sa1, v.sa0};
        stq_data       = {{((SD-2)*XL){1'b0}}, v.sd1, v.sd0};
        mem_ready      = v.mr;
        fwd_ready      = v.fr;
    endtask

    task automatic check_out(input vec_t v, input int k);
        chk($sformatf("v%0d disp_ready", k), 32'(disp_ready), 32'(v.e_rdy));
        chk($sformatf("v%0d agu_valid", k), 32'(agu_valid), 32'(v.e_agu));
        chk($sformatf("v%0d mem_valid", k), 32'(mem_valid), 32'(v.e_mem));
        chk($sformatf("v%0d fwd_valid", k), 32'(fwd_valid), 32'(v.e_fwd));
        if (v.e_agu) begin
            chk($sformatf("v%0d agu_tag", k), 32'(agu_tag), 32'(v.e_atag));
            chk($sformatf("v%0d agu_base", k), agu_base, v.e_abase);
            chk($sformatf("v%0d agu_imm", k), agu_imm, v.e_aimm);
        end
        if (v.e_mem) begin
            chk($sformatf("v%0d mem_tag", k), 32'(mem_tag), 32'(v.e_mtag));
            chk($sformatf("v%0d mem_addr", k), mem_addr, v.e_maddr);
        end
        if (v.e_fwd) begin
            chk($sformatf("v%0d fwd_tag", k), 32'(fwd_tag), 32'(v.e_ftag));
            chk($sformatf("v%0d fwd_data", k), fwd_data, v.e_fdata);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_out(v, n_vec);
        n_vec++;
    endtask

    // One-shot inputs and expectations reset after each vector; STQ, head and readies persist.
    task automatic clr_one();
        t.flush = 1'b0; t.dv = 1'b0; t.cv = '0; t.rv = 1'b0;
        t.e_rdy = 1'b1; t.e_agu = 1'b0; t.e_mem = 1'b0; t.e_fwd = 1'b0;
    endtask
    task automatic push();
        tbl.push_back(t);
        clr_one();
    endtask
    task automatic step();
        apply(t);
        clr_one();
    endtask
    task automatic disp(input int tag, input bit rdy, input int btag, input int base, input int imm);
        t.dv = 1'b1; t.dtag = TW'(tag); t.drdy = rdy; t.dbtag = TW'(btag);
        t.dbase = XL'(base); t.dimm = XL'(imm);
    endtask
    task automatic ea(input int tag, input int base, input int imm);
        t.e_agu = 1'b1; t.e_atag = TW'(tag); t.e_abase = XL'(base); t.e_aimm = XL'(imm);
    endtask
    task automatic em(input int tag, input int addr);
        t.e_mem = 1'b1; t.e_mtag = TW'(tag); t.e_maddr = XL'(addr);
    endtask
    task automatic ef(input int tag, input int data);
        t.e_fwd = 1'b1; t.e_ftag = TW'(tag); t.e_fdata = XL'(data);
    endtask
    task automatic resp(input int tag, input int addr);
        t.rv = 1'b1; t.rtag = TW'(tag); t.raddr = XL'(addr);
    endtask

    initial begin
        t = '0;
        clr_one();
        // Ready base through AGU to D-cache
        t.ar = 1'b1; t.mr = 1'b1;
        disp(3, 1, 0, 'h100, 4);                        push();
        ea(3, 'h100, 4);                                push();
        resp(3, 'h104);                                 push();
        em(3, 'h104);                                   push();
        push();
        // CDB wakeup on port 1; masked port 0; stray AGU response; mem back-pressure
        t.ar = 1'b0; t.mr = 1'b0;
        disp(5, 0, 2, 0, 8);                            push();
        t.cv = 2'b10; t.ct0 = 2; t.cd0 = 'h99; t.ct1 = 2; t.cd1 = 'h40; push();
        t.ar = 1'b1; ea(5, 'h40, 8);                    push();
        t.ar = 1'b0; resp(9, 'h77);                     push();
        resp(5, 'h48);                                  push();
        em(5, 'h48);                                    push();
        t.mr = 1'b1; em(5, 'h48);                       push();
        push();
        // Forwarding: older store tag 1 forwards, younger tag 6 ignored, then older tag 3 wins
        t.sv = 2'b11; t.sav = 2'b11; t.sdv = 2'b11;
        t.st0 = 1; t.sa0 = 'h200; t.sd0 = 'hDEAD;
        t.st1 = 6; t.sa1 = 'h200; t.sd1 = 'hBEEF;
        t.ar = 1'b1; t.fr = 1'b0;
        disp(4, 1, 0, 'h200, 0);                        push();
        ea(4, 'h200, 0);                                push();
        resp(4, 'h200);                                 push();
        ef(4, 'hDEAD);                                  push();
        t.st1 = 3; ef(4, 'hBEEF);                       push();
        t.fr = 1'b1; ef(4, 'hBEEF);                     push();
        push();
        // Blocking: unknown older address, then match without data, then disjoint address
        t.sv = 2'b01; t.sav = 2'b00; t.sdv = 2'b00; t.st0 = 1; t.sa0 = 'h0;
        disp(4, 1, 0, 'h300, 0);                        push();
        ea(4, 'h300, 0);                                push();
        resp(4, 'h300);                                 push();
        push();
        t.sav = 2'b01; t.sa0 = 'h300;                   push();
        t.sa0 = 'h400; em(4, 'h300);                    push();
        push();
        // Lowest CDB port wins, same-cycle capture at dispatch
        t.sv = 2'b00; t.ar = 1'b0; t.mr = 1'b0; t.fr = 1'b0;
        disp(7, 0, 9, 0, 1);                            push();
        t.cv = 2'b11; t.ct0 = 9; t.cd0 = 'h70; t.ct1 = 9; t.cd1 = 'h90;
        disp(10, 0, 9, 0, 2);                           push();
        ea(7, 'h70, 1);                                 push();
        t.ar = 1'b1; ea(7, 'h70, 1);                    push();
        t.ar = 1'b0; ea(10, 'h70, 2);                   push();
        t.flush = 1'b1; ea(10, 'h70, 2);                push();
        // Age wrap around rob_head 62, fill, flush, late AGU response dropped
        t.head = 62;
        disp(1, 1, 0, 'h10, 1);                         push();
        disp(63, 1, 0, 'h20, 2); ea(1, 'h10, 1);        push();
        ea(63, 'h20, 2);                                push();
        t.ar = 1'b1; ea(63, 'h20, 2);                   push();
        t.ar = 1'b0; disp(2, 1, 0, 'h30, 3); ea(1, 'h10, 1); push();
        disp(3, 1, 0, 'h40, 4); ea(1, 'h10, 1);         push();
        disp(5, 1, 0, 'h50, 5); t.e_rdy = 1'b0; ea(1, 'h10, 1); push();
        t.flush = 1'b1; disp(5, 1, 0, 'h50, 5); t.e_rdy = 1'b0; ea(1, 'h10, 1); push();
        t.mr = 1'b1; resp(63, 'h500);                   push();
        push();

        rst_n = 1'b0;
        drive(t);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Flush with three waiting entries, then their producer broadcasts
        t.head = 0; t.mr = 1'b0; t.ar = 1'b0;
        disp(20, 0, 40, 0, 0);                          step();
        disp(21, 0, 40, 0, 0);                          step();
        disp(22, 0, 40, 0, 0);                          step();
        t.flush = 1'b1;                                 step();
        t.cv = 2'b01; t.ct0 = 40; t.cd0 = 'h5;          step();
        step();

        // Reset asserted in the middle of an AGU handshake
        disp(30, 1, 0, 'h30, 0);                        step();
        t.ar = 1'b1; ea(30, 'h30, 0);
        @(negedge clk);
        drive(t);
        #1;
        check_out(t, n_vec);
        n_vec++;
        #1 rst_n = 1'b0;
        #1;
        chk("rst agu_valid", 32'(agu_valid), 32'd0);
        chk("rst mem_valid", 32'(mem_valid), 32'd0);
        chk("rst fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst disp_ready", 32'(disp_ready), 32'd1);
        n_vec++;
        clr_one();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
